// File: rtl/move_packet_framer.sv
// Move packet framer: queues 12-bit move packets, frames them as 3-byte
// sequenced messages and retransmits on NAK or ack timeout.
module move_packet_framer #(
    parameter int PKT_W       = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 5_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             moved,
    input  logic [PKT_W-1:0] output_packet,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             ack_valid,
    input  logic             ack_ok,
    input  logic [1:0]       ack_seq,
    output logic             busy,
    output logic             fifo_full,
    output logic             overflow,
    output logic             link_error
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = $clog2(ACK_TIMEOUT);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SEND0    = 3'd2,
        ST_SEND1    = 3'd3,
        ST_SEND2    = 3'd4,
        ST_WAIT_ACK = 3'd5
    } state_e;

    function automatic logic [7:0] frame_b0(input logic [1:0] seq, input logic [PKT_W-1:0] pkt);
        return {2'b10, seq, pkt[11:8]};
    endfunction

    function automatic logic [7:0] frame_b1(input logic [PKT_W-1:0] pkt);
        return pkt[7:0];
    endfunction

    // B2 is a simple XOR check byte over the header and payload bytes.
    function automatic logic [7:0] frame_b2(input logic [1:0] seq, input logic [PKT_W-1:0] pkt);
        return frame_b0(seq, pkt) ^ frame_b1(pkt);
    endfunction

    logic [PKT_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    state_e             state_q, state_d;
    logic [PKT_W-1:0]   frame_q, frame_d;
    logic [1:0]         seq_q, seq_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, fifo_full_q, overflow_q;
    logic               link_error_q, link_error_d;
    logic               push_s, pop_s, drop_s, fire_s, ack_match_s, timeout_s;

    // The LOAD pop frees a slot in the same cycle, so a push to a full queue is accepted then.
    assign pop_s       = (state_q == ST_LOAD);
    assign push_s      = moved && (!fifo_full_q || pop_s);
    assign drop_s      = moved && fifo_full_q && !pop_s;
    assign fire_s      = tx_valid_q && tx_ready;
    assign ack_match_s = ack_valid && (ack_seq == seq_q);
    assign timeout_s   = (timer_q == TIMER_W'(ACK_TIMEOUT - 1));

    // Queue occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pending-packet queue storage and pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= output_packet;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Framing / retransmission next-state logic
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        seq_d        = seq_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        link_error_d = link_error_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                frame_d = fifo_mem_q[rd_ptr_q];
                retry_d = '0;
                state_d = ST_SEND0;
            end
            ST_SEND0: begin
                if (fire_s) state_d = ST_SEND1;
                else        state_d = ST_SEND0;
            end
            ST_SEND1: begin
                if (fire_s) state_d = ST_SEND2;
                else        state_d = ST_SEND1;
            end
            ST_SEND2: begin
                if (fire_s) begin
                    state_d = ST_WAIT_ACK;
                    timer_d = '0;
                end else begin
                    state_d = ST_SEND2;
                end
            end
            ST_WAIT_ACK: begin
                timer_d = timer_q + TIMER_W'(1);
                // An ACK wins over a timeout landing in the same cycle.
                if (ack_match_s && ack_ok) begin
                    seq_d   = seq_q + 2'd1;
                    state_d = ST_IDLE;
                end else if ((ack_match_s && !ack_ok) || timeout_s) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_SEND0;
                    end else begin
                        link_error_d = 1'b1;
                        seq_d        = seq_q + 2'd1;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output byte selection for the upcoming state
    always_comb begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        case (state_d)
            ST_SEND0: begin
                tx_valid_d = 1'b1;
                tx_data_d  = frame_b0(seq_d, frame_d);
            end
            ST_SEND1: begin
                tx_valid_d = 1'b1;
                tx_data_d  = frame_b1(frame_d);
            end
            ST_SEND2: begin
                tx_valid_d = 1'b1;
                tx_data_d  = frame_b2(seq_d, frame_d);
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // State, frame and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            seq_q        <= 2'd0;
            retry_q      <= '0;
            timer_q      <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            fifo_full_q  <= 1'b0;
            overflow_q   <= 1'b0;
            link_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            seq_q        <= seq_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= (state_d != ST_IDLE) || (count_d != '0);
            fifo_full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
            overflow_q   <= overflow_q | drop_s;
            link_error_q <= link_error_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign fifo_full  = fifo_full_q;
    assign overflow   = overflow_q;
    assign link_error = link_error_q;

endmodule

// File: tb/tb_move_packet_framer.sv
// Directed + randomized bench for move_packet_framer with a frame-level
// reference model (byte arithmetic, sequence counter, transfer log).
module tb_move_packet_framer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        moved = 1'b0;
    logic [11:0] output_packet = 12'h000;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        ack_valid = 1'b0;
    logic        ack_ok = 1'b0;
    logic [1:0]  ack_seq = 2'd0;
    logic        busy, fifo_full, overflow, link_error;

    move_packet_framer #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .moved(moved), .output_packet(output_packet),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .ack_valid(ack_valid), .ack_ok(ack_ok), .ack_seq(ack_seq),
        .busy(busy), .fifo_full(fifo_full), .overflow(overflow), .link_error(link_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_n = 0;
    int hold_viol = 0;
    int stall_cnt = 0;
    logic [7:0] tx_log [0:1023];
    int         tx_cyc [0:1023];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int rd = 0;
    int exp_seq = 0;
    int ready_mode = 0;
    int bp_i = 0;
    logic [3:0] bp_pat = 4'b1001;

    // Free-running cycle counter for transfer timestamps
    always @(posedge clk) cyc <= cyc + 1;

    // Transfer logger and hold-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !(tx_valid === 1'b1 && tx_data === prev_data))
                hold_viol <= hold_viol + 1;
            if (tx_valid && !tx_ready) stall_cnt <= stall_cnt + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
            if (tx_valid && tx_ready) begin
                tx_log[tx_n] <= tx_data;
                tx_cyc[tx_n] <= cyc;
                tx_n         <= tx_n + 1;
            end
        end
    end

    function automatic logic [7:0] model_byte(input int k, input int seq, input int pkt);
        int b0, b1;
        b0 = 128 + (seq % 4) * 16 + (pkt / 256) % 16;
        b1 = pkt % 256;
        case (k)
            0:       return 8'(b0);
            1:       return 8'(b1);
            default: return 8'(b0 ^ b1);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin
                tx_ready = bp_pat[bp_i];
                bp_i = (bp_i + 1) % 4;
            end
            default: tx_ready = 1'b0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic send_move(input logic [11:0] pkt);
        moved = 1'b1;
        output_packet = pkt;
        tick();
        moved = 1'b0;
    endtask

    task automatic send_ack(input logic ok, input int seq);
        ack_valid = 1'b1;
        ack_ok = ok;
        ack_seq = 2'(seq);
        tick();
        ack_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int budget;
        budget = 200;
        while (tx_n < rd + n && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("wait_bytes_bound", 32'(tx_n), 32'(rd + n));
    endtask

    task automatic expect_frame(input string tag, input int pkt, input int seq);
        wait_bytes(3);
        for (int k = 0; k < 3; k++)
            chk(tag, {24'h0, tx_log[rd + k]}, {24'h0, model_byte(k, seq, pkt)});
        rd += 3;
    endtask

    initial begin
        logic [11:0] pk [0:5];
        logic [11:0] p;
        int last_b2;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_link_error", 32'(link_error), 32'd0);

        // Single move with latency check
        send_move(12'hA5C);
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_c1", 32'(tx_valid), 32'd0);
        tick();
        chk("lat_c2", 32'(tx_valid), 32'd0);
        tick();
        chk("lat_c3", 32'(tx_valid), 32'd1);
        expect_frame("single", 12'hA5C, exp_seq);
        chk("single_b0", {24'h0, tx_log[rd - 3]}, 32'h8A);
        chk("single_b1", {24'h0, tx_log[rd - 2]}, 32'h5C);
        chk("single_b2", {24'h0, tx_log[rd - 1]}, 32'hD6);
        send_ack(1'b1, exp_seq);
        exp_seq = (exp_seq + 1) % 4;
        chk("single_busy_fall", 32'(busy), 32'd0);
        p = 12'($urandom);
        send_move(p);
        expect_frame("next_seq1", p, exp_seq);
        send_ack(1'b1, exp_seq);
        exp_seq = (exp_seq + 1) % 4;

        // Reset, then NAK followed by ACK (with an ignored stale ack first)
        reset = 1'b1; tick(); reset = 1'b0;
        exp_seq = 0;
        send_move(12'h123);
        expect_frame("nak_first", 12'h123, exp_seq);
        chk("nak_b0", {24'h0, tx_log[rd - 3]}, 32'h81);
        chk("nak_b2", {24'h0, tx_log[rd - 1]}, 32'hA2);
        send_ack(1'b1, exp_seq + 2);
        send_ack(1'b0, exp_seq);
        expect_frame("nak_resend", 12'h123, exp_seq);
        send_ack(1'b1, exp_seq);
        exp_seq = (exp_seq + 1) % 4;
        chk("nak_link_error", 32'(link_error), 32'd0);

        // Backpressure with 1,0,0,1 ready pattern
        ready_mode = 1;
        p = 12'($urandom);
        send_move(p);
        expect_frame("bp_frame", p, exp_seq);
        ready_mode = 0;
        send_ack(1'b1, exp_seq);
        exp_seq = (exp_seq + 1) % 4;
        repeat (8) tick();
        chk("bp_no_dup", 32'(tx_n), 32'(rd));
        chk("bp_stalled", 32'(stall_cnt > 0), 32'd1);

        // Five acked random frames: sequence wraps 3 -> 0
        for (int i = 0; i < 5; i++) begin
            p = 12'($urandom);
            send_move(p);
            expect_frame("seq_wrap", p, exp_seq);
            send_ack(1'b1, exp_seq);
            exp_seq = (exp_seq + 1) % 4;
        end

        // Timeout exhaustion: 1 + 3 retries, then abandon
        pk[0] = 12'($urandom);
        pk[1] = 12'($urandom);
        send_move(pk[0]);
        send_move(pk[1]);
        last_b2 = 0;
        for (int r = 0; r < 4; r++) begin
            expect_frame("to_frame", pk[0], exp_seq);
            if (r > 0) chk("to_gap", 32'(tx_cyc[rd - 3] - last_b2), 32'(TO + 1));
            last_b2 = tx_cyc[rd - 1];
            chk("to_no_link_error", 32'(link_error), 32'd0);
            if (r == 0) send_ack(1'b1, exp_seq + 1);
        end
        exp_seq = (exp_seq + 1) % 4;
        expect_frame("to_next_pkt", pk[1], exp_seq);
        chk("to_link_error", 32'(link_error), 32'd1);
        send_ack(1'b1, exp_seq);
        exp_seq = (exp_seq + 1) % 4;

        // FIFO overflow with transmitter stalled
        chk("ovf_pre", 32'(overflow), 32'd0);
        ready_mode = 2;
        for (int i = 0; i < 6; i++) begin
            pk[i] = 12'($urandom);
            send_move(pk[i]);
        end
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            expect_frame("ovf_order", pk[i], exp_seq);
            send_ack(1'b1, exp_seq);
            exp_seq = (exp_seq + 1) % 4;
        end
        repeat (8) tick();
        chk("ovf_drop", 32'(tx_n), 32'(rd));
        chk("ovf_idle", 32'(busy), 32'd0);

        // Reset during SEND1 discards frame and queue
        send_move(12'($urandom));
        send_move(12'($urandom));
        wait_bytes(1);
        reset = 1'b1; tick(); reset = 1'b0;
        exp_seq = 0;
        rd = tx_n;
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_overflow", 32'(overflow), 32'd0);
        chk("rst_mid_link_error", 32'(link_error), 32'd0);
        chk("rst_mid_fifo_full", 32'(fifo_full), 32'd0);
        repeat (10) tick();
        chk("rst_mid_discard", 32'(tx_n), 32'(rd));
        p = 12'($urandom);
        send_move(p);
        expect_frame("post_rst", p, exp_seq);
        send_ack(1'b1, exp_seq);

        chk("hold_stable", 32'(hold_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_packet_framer.md
Name: move_packet_framer

Overview:
- Sits between the board controller and the UART byte transmitter.
- Each `moved` strobe from the board queues the 12-bit move packet in a small FIFO. The block frames the packet into a 3-byte sequenced message and pushes the bytes over a valid/ready handshake.
- It then waits for the opponent's acknowledge and retransmits on NAK or timeout, up to a bounded retry count.

Parameters:
- PKT_W, 12, move packet width (fixed framing assumes 12)
- FIFO_DEPTH, 4, pending-packet queue depth (power of two)
- ACK_TIMEOUT, 5_000_000, clk cycles to wait for ack after the last byte is accepted (100 ms at 50 MHz)
- MAX_RETRY, 3, retransmissions allowed after the first send before the packet is abandoned

Ports:
- clk  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high reset
- moved  in  1  one-cycle strobe: output_packet valid
- output_packet  in  12  move packet from board controller
- tx_ready  in  1  UART transmitter can accept a byte
- tx_valid  out  1  tx_data valid
- tx_data  out  8  framed byte
- ack_valid  in  1  one-cycle strobe: ack byte received from peer
- ack_ok  in  1  with ack_valid: 1=ACK, 0=NAK
- ack_seq  in  2  sequence number carried by the ack
- busy  out  1  FSM not in IDLE, or FIFO not empty
- fifo_full  out  1  queue holds FIFO_DEPTH packets
- overflow  out  1  sticky: a moved strobe was dropped because the FIFO was full
- link_error  out  1  sticky: a packet was abandoned after MAX_RETRY retries

Behaviour:
- Reset: all outputs 0, FIFO empty, seq=0, retry=0, timer=0, FSM=IDLE. Reset mid-frame aborts immediately. tx_valid is 0 the cycle after reset is sampled, and queued packets are discarded.
- FIFO push: on moved && !fifo_full. A moved strobe when full is dropped and overflow is set. Simultaneous push and pop when full is allowed; the pop frees the slot the same cycle, so no drop occurs.
- Frame bytes:
  - B0 = {2'b10, seq[1:0], pkt[11:8]}
  - B1 = pkt[7:0]
  - B2 = B0 ^ B1
- FSM states: IDLE, LOAD, SEND0, SEND1, SEND2, WAIT_ACK.
  - IDLE: if FIFO not empty, go to LOAD.
  - LOAD: latch the FIFO head into a frame register and pop it; retry=0. Next state SEND0.
  - SENDn: tx_valid=1, tx_data=Bn. tx_data stays stable while tx_valid && !tx_ready. A transfer happens on a cycle with tx_valid && tx_ready. On transfer, advance to SEND(n+1); after SEND2, go to WAIT_ACK with timer=0. tx_valid deasserts the cycle after the B2 transfer.
  - WAIT_ACK: timer increments each cycle.
    - ack_valid && ack_ok && ack_seq==seq: seq<=seq+1 (wraps 3->0), go to IDLE.
    - NAK with matching seq, or timer==ACK_TIMEOUT-1: if retry<MAX_RETRY, retry++ and go to SEND0 (same seq, same packet). Otherwise set link_error, seq++, go to IDLE (packet abandoned).
    - ack_valid with a mismatched seq is ignored; the timer keeps running.
- ack_valid in any state other than WAIT_ACK is ignored.
- Latency: moved into an empty, idle block gives tx_valid=1 on the 3rd cycle after the strobe (push, IDLE->LOAD, LOAD->SEND0).
- busy = (FSM!=IDLE) || FIFO non-empty.
- overflow and link_error clear only on reset.

Test Plan:
- Single move: moved with output_packet=12'hA5C, tx_ready held 1, ack(ok, seq=0) after the 3rd byte -> tx bytes 0x8A, 0x5C, 0xD6. busy falls to 0 one cycle after the ack; the next frame uses seq=1.
- Backpressure: tx_ready toggled 1,0,0,1,... -> each byte held stable while tx_ready=0; exactly 3 transfers occur, and there are no duplicate bytes.
- NAK then ACK: packet 12'h123, NAK seq=0, then ACK seq=0 -> frame 0x81, 0x23, 0xA2 sent twice; link_error stays 0; seq advances to 1.
- Timeout exhaustion: ACK_TIMEOUT=16, no ack -> 4 transmissions total (1 + MAX_RETRY) spaced 16 cycles after each B2. link_error=1; the next queued packet is framed with seq=1.
- FIFO overflow: tx_ready=0 and 6 moved strobes -> the first packet is popped into LOAD, 4 are queued, fifo_full=1, and the 6th strobe sets overflow. After ACKs, 5 frames are sent in order.
- Seq wrap and reset: 4 acked frames give seq values 0,1,2,3 and the 5th frame uses seq=0. Asserting reset during SEND1 gives tx_valid=0 the next cycle, busy=0 and all stickies cleared.
